// File: rtl/ahb_ui_sequencer_pkg.sv
// Shared types for the AHB master UI command sequencer.
// Holds the FSM encoding and the latched command bundle.
package ahb_ui_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_END
  } seq_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
  } cmd_t;

endpackage

// File: rtl/ahb_ui_wfifo.sv
// Write-data FIFO feeding the master UI.
// The head is read straight from the storage registers.
module ahb_ui_wfifo #(
  parameter int DATA_WDT   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_push,
  input  logic [DATA_WDT-1:0] i_data,
  input  logic                i_pop,
  output logic [DATA_WDT-1:0] o_head,
  output logic                o_full,
  output logic                o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_WDT-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_hclk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ahb_ui_sequencer.sv
// Command front end for the AHB master UI.
// Walks one burst beat by beat, advancing only on the master's next strobe.
module ahb_ui_sequencer
  import ahb_ui_sequencer_pkg::*;
#(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_wr,
  input  logic [DATA_WDT-1:0] i_wdata,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic                i_next,
  output logic [DATA_WDT-1:0] o_data,
  output logic                o_dav,
  output logic [31:0]         o_addr,
  output logic [2:0]          o_size,
  output logic                o_wr,
  output logic                o_rd,
  output logic [BEAT_WDT-1:0] o_min_len,
  output logic                o_cont,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [BEAT_WDT-1:0] BEAT_ONE = 1;

  seq_state_e          state_q;
  cmd_t                cmd_q;
  logic [BEAT_WDT-1:0] len_q;
  logic [BEAT_WDT-1:0] rem_q;
  logic                done_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                beat;
  logic                last;

  ahb_ui_wfifo #(
    .DATA_WDT   (DATA_WDT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .i_hclk   (i_hclk),
    .i_hreset (i_hreset),
    .i_push   (i_wdata_valid),
    .i_data   (i_wdata),
    .i_pop    (beat && cmd_q.wr),
    .o_head   (o_data),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  always_comb begin
    o_rd   = 1'b0;
    o_wr   = 1'b0;
    o_dav  = 1'b0;
    o_cont = 1'b0;
    unique case (state_q)
      ST_START: begin
        // A write with no data yet leaves the master idle
        o_rd  = !cmd_q.wr;
        o_wr  = cmd_q.wr && !fifo_empty;
        o_dav = cmd_q.wr && !fifo_empty;
      end
      ST_STREAM: begin
        o_rd   = !cmd_q.wr;
        o_wr   = cmd_q.wr;
        o_dav  = cmd_q.wr && !fifo_empty;
        o_cont = 1'b1;
      end
      default: ;
    endcase
  end

  assign beat          = i_next && (o_rd || (o_wr && o_dav));
  assign last          = (rem_q == BEAT_ONE);
  assign o_cmd_ready   = (state_q == ST_IDLE) && !i_hreset;
  assign o_wdata_ready = !fifo_full;
  assign o_addr        = cmd_q.addr;
  assign o_size        = cmd_q.size;
  assign o_min_len     = len_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            cmd_q.addr <= i_cmd_addr;
            cmd_q.size <= i_cmd_size;
            cmd_q.wr   <= i_cmd_wr;
            len_q      <= i_cmd_len;
            rem_q      <= i_cmd_len;
            state_q    <= (i_cmd_len != '0) ? ST_START : ST_END;
          end
        end
        ST_START, ST_STREAM: begin
          if (beat) begin
            rem_q   <= rem_q - BEAT_ONE;
            state_q <= last ? ST_END : ST_STREAM;
          end
        end
        ST_END: begin
          if (i_next) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
